cpu_core_param: RTL and testbench

CPU_CORE_PARAM -- requirements
Module: cpu_core_param

---
 rtl/cpu_core_param.sv | 142 ++++++++++++++
 tb/tb_cpu_core_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_param.sv
// Minimal accumulator-style core: fetch/execute over a handshaked instruction port.
// Two registers (A, B), an output register, carry/zero flags and an ADDR_W-bit IP.
module cpu_core_param #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [DATA_W+3:0]   imem_data,
  input  logic [DATA_W-1:0]   in_port,
  output logic [DATA_W-1:0]   out_port,
  output logic                halted,
  output logic                retire
);

  localparam int unsigned OP_W    = 4;
  localparam int unsigned INSTR_W = DATA_W + OP_W;

  localparam logic [OP_W-1:0] OP_ADD_A = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD_B = 4'b0101;
  localparam logic [OP_W-1:0] OP_MOV_A = 4'b0011;
  localparam logic [OP_W-1:0] OP_MOV_B = 4'b0111;
  localparam logic [OP_W-1:0] OP_A_B   = 4'b0001;
  localparam logic [OP_W-1:0] OP_B_A   = 4'b0100;
  localparam logic [OP_W-1:0] OP_IN_A  = 4'b0010;
  localparam logic [OP_W-1:0] OP_IN_B  = 4'b0110;
  localparam logic [OP_W-1:0] OP_OUT_B = 4'b1001;
  localparam logic [OP_W-1:0] OP_OUT_I = 4'b1011;
  localparam logic [OP_W-1:0] OP_SUB_A = 4'b1000;
  localparam logic [OP_W-1:0] OP_JMP   = 4'b1111;
  localparam logic [OP_W-1:0] OP_JNC   = 4'b1110;
  localparam logic [OP_W-1:0] OP_JZ    = 4'b1010;
  localparam logic [OP_W-1:0] OP_HLT   = 4'b1100;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ip_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                cf_q;
  logic                zf_q;
  logic [OP_W-1:0]     ir_op;
  logic [DATA_W-1:0]   ir_imm;

  logic [DATA_W:0]     sum_a;
  logic [DATA_W:0]     sum_b;
  logic [DATA_W:0]     diff_a;
  logic [ADDR_W-1:0]   jmp_tgt;
  logic [ADDR_W-1:0]   ip_inc;

  // Request is a decode of the state register, gated so nothing is fetched while in reset.
  assign imem_req  = (state == S_FETCH) && !rst;
  assign imem_addr = ip_q;

  // Arithmetic and jump-target datapath for the latched instruction.
  always_comb begin
    sum_a   = {1'b0, a_q} + {1'b0, ir_imm};
    sum_b   = {1'b0, b_q} + {1'b0, ir_imm};
    diff_a  = {1'b0, a_q} - {1'b0, ir_imm};
    jmp_tgt = ADDR_W'(ir_imm);
    ip_inc  = ip_q + ADDR_W'(1);
  end

  // Fetch/execute/halt sequencer with all architectural state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      ip_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      ir_op    <= '0;
      ir_imm   <= '0;
      out_port <= '0;
      halted   <= 1'b0;
      retire   <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir_op  <= imem_data[INSTR_W-1:DATA_W];
            ir_imm <= imem_data[DATA_W-1:0];
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          retire <= 1'b1;
          state  <= S_FETCH;
          ip_q   <= ip_inc;
          case (ir_op)
            OP_ADD_A: begin
              a_q  <= sum_a[DATA_W-1:0];
              cf_q <= sum_a[DATA_W];
              zf_q <= (sum_a[DATA_W-1:0] == '0);
            end
            OP_ADD_B: begin
              b_q  <= sum_b[DATA_W-1:0];
              cf_q <= sum_b[DATA_W];
              zf_q <= (sum_b[DATA_W-1:0] == '0);
            end
            OP_SUB_A: begin
              a_q  <= diff_a[DATA_W-1:0];
              cf_q <= diff_a[DATA_W];
              zf_q <= (diff_a[DATA_W-1:0] == '0);
            end
            OP_MOV_A: a_q      <= ir_imm;
            OP_MOV_B: b_q      <= ir_imm;
            OP_A_B:   a_q      <= b_q;
            OP_B_A:   b_q      <= a_q;
            OP_IN_A:  a_q      <= in_port;
            OP_IN_B:  b_q      <= in_port;
            OP_OUT_B: out_port <= b_q;
            OP_OUT_I: out_port <= ir_imm;
            OP_JMP:   ip_q     <= jmp_tgt;
            OP_JNC:   if (!cf_q) ip_q <= jmp_tgt;
            OP_JZ:    if (zf_q)  ip_q <= jmp_tgt;
            OP_HLT: begin
              // IP stays on the HLT itself so the stop address is observable.
              ip_q   <= ip_q;
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: ;
          endcase
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_param.sv
// Randomized self-checking bench for cpu_core_param against an instruction-level model.
module tb_cpu_core_param;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic          imem_req;
  logic          imem_ack;
  logic [DW+3:0] imem_data;
  logic [DW-1:0] in_port;
  logic [DW-1:0] out_port;
  logic          halted;
  logic          retire;

  cpu_core_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .in_port   (in_port),
    .out_port  (out_port),
    .halted    (halted),
    .retire    (retire)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Instruction memory and architectural model state.
  logic [7:0] prog [16];
  int m_a, m_b, m_o, m_ip;
  bit m_cf, m_zf, m_halted;
  int safe_ops [12] = '{0, 5, 3, 7, 1, 4, 2, 6, 9, 11, 8, 13};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_o = 0; m_ip = 0;
    m_cf = 0; m_zf = 0; m_halted = 0;
  endtask

  // One instruction at the architectural level, plain modular arithmetic.
  task automatic model_exec(input logic [7:0] ins, input int inp);
    int op, imm, s, nip;
    op  = int'(ins[7:4]);
    imm = int'(ins[3:0]);
    nip = (m_ip + 1) % 16;
    case (op)
      0:  begin s = m_a + imm; m_cf = (s > 15); m_a = s % 16; m_zf = (m_a == 0); end
      5:  begin s = m_b + imm; m_cf = (s > 15); m_b = s % 16; m_zf = (m_b == 0); end
      8:  begin m_cf = (m_a < imm); m_a = (m_a - imm + 16) % 16; m_zf = (m_a == 0); end
      3:  m_a = imm;
      7:  m_b = imm;
      1:  m_a = m_b;
      4:  m_b = m_a;
      2:  m_a = inp;
      6:  m_b = inp;
      9:  m_o = m_b;
      11: m_o = imm;
      15: nip = imm;
      14: if (!m_cf) nip = imm;
      10: if (m_zf) nip = imm;
      12: begin m_halted = 1; nip = m_ip; end
      default: ;
    endcase
    m_ip = nip;
  endtask

  task automatic check_arch(input string tag);
    check_eq({tag, "_a"},      dut.a_q,   m_a);
    check_eq({tag, "_b"},      dut.b_q,   m_b);
    check_eq({tag, "_out"},    out_port,  m_o);
    check_eq({tag, "_cf"},     dut.cf_q,  m_cf);
    check_eq({tag, "_zf"},     dut.zf_q,  m_zf);
    check_eq({tag, "_ip"},     imem_addr, m_ip);
    check_eq({tag, "_halted"}, halted,    m_halted);
  endtask

  // Hold rst for n cycles, check the reset image while rst is still high, then release.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_arch("rst");
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_retire", retire, 0);
    rst = 1'b0;
  endtask

  // Serve fetches with waits, check timing every cycle and state at each retire.
  task automatic run_prog(input int n_instr, input int wait_max, input bit rnd_wait);
    int retired, budget, waited, need, cyc, ack_cyc;
    logic [7:0] ins;
    retired = 0; budget = 0; waited = 0; cyc = 0; ack_cyc = -10; ins = 8'h0;
    need = rnd_wait ? int'($urandom_range(wait_max, 0)) : wait_max;
    while (retired < n_instr && budget < 2000) begin
      @(negedge clk);
      budget++;
      cyc++;
      imem_ack = 1'b0;
      in_port  = DW'($urandom);
      check_eq("retire_timing", retire, (cyc == ack_cyc + 2));
      if (cyc == ack_cyc + 2) begin
        retired++;
        check_arch("retire");
      end
      if (cyc == ack_cyc + 1) begin
        check_eq("req_exec", imem_req, 0);
        model_exec(ins, int'(in_port));
        imem_ack  = 1'($urandom);
        imem_data = 8'($urandom);
      end else if (!m_halted && retired < n_instr) begin
        check_eq("req_fetch", imem_req, 1);
        check_eq("fetch_addr", imem_addr, m_ip);
        if (waited >= need) begin
          imem_ack  = 1'b1;
          imem_data = prog[m_ip];
          ins       = prog[m_ip];
          ack_cyc   = cyc;
          waited    = 0;
          need      = rnd_wait ? int'($urandom_range(wait_max, 0)) : wait_max;
        end else begin
          waited++;
        end
      end
    end
    imem_ack = 1'b0;
    if (retired < n_instr) check_eq("run_timeout", retired, n_instr);
  endtask

  task automatic load_fill(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) prog[i] = fill;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_data = '0; in_port = '0;
    model_reset();

    // ADD overflow, JNC not taken, OUT immediate, zero wait states
    load_fill(8'hD0);
    prog[0] = 8'h39; prog[1] = 8'h09; prog[2] = 8'hE0; prog[3] = 8'hB5;
    do_reset(2);
    run_prog(4, 0, 1'b0);
    check_eq("p1_a", dut.a_q, 2);
    check_eq("p1_cf", dut.cf_q, 1);
    check_eq("p1_zf", dut.zf_q, 0);
    check_eq("p1_out", out_port, 5);
    check_eq("p1_next_ip", imem_addr, 4);

    // Same program with 3 wait states per fetch
    do_reset(1);
    run_prog(4, 3, 1'b0);
    check_eq("p1w_a", dut.a_q, 2);
    check_eq("p1w_cf", dut.cf_q, 1);
    check_eq("p1w_out", out_port, 5);

    // SUB to zero then JZ taken
    load_fill(8'hD0);
    prog[0] = 8'h33; prog[1] = 8'h83; prog[2] = 8'hA7;
    do_reset(1);
    run_prog(3, 0, 1'b0);
    check_eq("p2_a", dut.a_q, 0);
    check_eq("p2_zf", dut.zf_q, 1);
    check_eq("p2_cf", dut.cf_q, 0);
    check_eq("p2_ip", imem_addr, 7);
    run_prog(1, 0, 1'b0);

    // JMP to the last address, NOP there wraps IP to 0
    load_fill(8'hD0);
    prog[0] = 8'hFF; prog[15] = 8'hD0;
    do_reset(1);
    run_prog(2, 0, 1'b0);
    check_eq("p3_wrap_ip", imem_addr, 0);
    run_prog(1, 1, 1'b0);

    // Random programs without HLT, random wait states and input data
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        prog[i] = 8'($urandom);
        if (prog[i][7:4] == 4'hC) prog[i][7:4] = 4'hD;
      end
      do_reset(1);
      run_prog(30, 3, 1'b1);
    end

    // HLT at address 4: stays halted, ignores acks, leaves only through reset
    for (int i = 0; i < 4; i++) prog[i] = {4'(safe_ops[$urandom_range(11, 0)]), 4'($urandom)};
    prog[4] = 8'hC0;
    do_reset(1);
    run_prog(5, 2, 1'b1);
    check_eq("hlt_ip", imem_addr, 4);
    check_eq("hlt_halted", halted, 1);
    repeat (6) begin
      @(negedge clk);
      imem_ack  = 1'($urandom);
      imem_data = 8'h3A;
      check_eq("hlt_req", imem_req, 0);
      check_eq("hlt_halted_hold", halted, 1);
      check_eq("hlt_retire", retire, 0);
      check_eq("hlt_ip_hold", imem_addr, 4);
      check_eq("hlt_a_hold", dut.a_q, m_a);
    end
    imem_ack = 1'b0;
    load_fill(8'hD0);
    prog[0] = 8'h3A;
    do_reset(1);
    check_eq("unhalt", halted, 0);
    run_prog(2, 0, 1'b0);

    // Reset while a fetch is waiting; the ack presented during rst must not be latched
    load_fill(8'hD0);
    prog[0] = 8'h39; prog[1] = 8'h09; prog[2] = 8'hB5;
    do_reset(1);
    run_prog(3, 3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_data = 8'h39;
    @(negedge clk);
    model_reset();
    check_arch("midrst");
    check_eq("midrst_req", imem_req, 0);
    rst = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    check_eq("midrst_fetch_req", imem_req, 1);
    check_eq("midrst_fetch_addr", imem_addr, 0);
    check_eq("midrst_no_retire", retire, 0);
    check_eq("midrst_a", dut.a_q, 0);
    run_prog(3, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Absolute time bound in case a wait is never satisfied.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
